// File: rtl/exec_controller.sv
// exec_controller: program-load / run / single-step sequencer for a
// UART-loaded soft CPU. Four debounced front-panel buttons, two level
// switches, all outputs registered.
// Build option: define EXEC_BREAKPOINT_EN to add a pc == bp_addr stop in RUN;
// without it bp_addr is ignored and no comparator exists.

module exec_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);
  logic [1:0]  sync;
  logic        level;
  logic [19:0] cnt;

  // 2-flop sync, then count consecutive samples disagreeing with the accepted level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pulse <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt >= DEBOUNCE_CYCLES - 20'd1) begin
        level <= sync[1];
        cnt   <= '0;
        pulse <= sync[1];
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end
endmodule

module exec_controller #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_byte_valid,
  input  logic       uart_load_done,
  input  logic       start_cpu,
  input  logic       step_mode,
  input  logic       btn_next,
  input  logic       btn_result,
  input  logic       btn_instr,
  input  logic       btn_flags,
  input  logic       instr_done,
  input  logic       cpu_halt,
  input  logic [7:0] pc,
  input  logic [7:0] bp_addr,
  output logic       cpu_en,
  output logic       cpu_rst,
  output logic [1:0] disp_sel,
  output logic       led_ready,
  output logic       led_halt,
  output logic       led_run
);
  localparam int NUM_BTN  = 4;
  localparam int B_NEXT   = 0;
  localparam int B_RESULT = 1;
  localparam int B_INSTR  = 2;
  localparam int B_FLAGS  = 3;

  typedef enum logic [2:0] {
    IDLE, LOADING, READY, RUN, STEP_WAIT, STEP_EXEC, HALTED
  } state_t;

  state_t             state, nxt;
  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic [1:0]         start_sync, step_sync;
  logic               start_s, step_s, run_ok;

  assign btn_raw = {btn_flags, btn_instr, btn_result, btn_next};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_db
    exec_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn_raw[i]),
      .pulse(btn_pulse[i])
    );
  end

  // slide switches are asynchronous to clk; synchronize before the FSM sees them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync <= '0;
      step_sync  <= '0;
    end else begin
      start_sync <= {start_sync[0], start_cpu};
      step_sync  <= {step_sync[0], step_mode};
    end
  end

  assign start_s = start_sync[1];
  assign step_s  = step_sync[1];

`ifdef EXEC_BREAKPOINT_EN
  logic bp_hit, bp_hold, step_prev;
  assign bp_hit = instr_done && (pc == bp_addr);
  // bp_hold pins STEP_WAIT after a breakpoint until btn_next or a step_mode toggle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bp_hold   <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_prev <= step_s;
      bp_hold   <= (nxt == STEP_WAIT) &&
                   ((state == RUN && !step_s && bp_hit) ||
                    (bp_hold && step_s == step_prev));
    end
  end
  assign run_ok = !step_s && !bp_hold;
`else
  // pc/bp_addr only feed the optional breakpoint comparator
  logic unused_bp;
  assign unused_bp = ^{pc, bp_addr};
  assign run_ok    = !step_s;
`endif

  // next state; order of tests encodes upload > halt > stop > mode > step
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (uart_byte_valid) nxt = LOADING;
      LOADING:   if (uart_load_done) nxt = READY;
      READY: begin
        if (uart_byte_valid)  nxt = LOADING;
        else if (start_s)     nxt = step_s ? STEP_WAIT : RUN;
      end
      RUN: begin
        if (uart_byte_valid)  nxt = LOADING;
        else if (cpu_halt)    nxt = HALTED;
        else if (!start_s)    nxt = READY;
        else if (step_s)      nxt = STEP_WAIT;
`ifdef EXEC_BREAKPOINT_EN
        else if (bp_hit)      nxt = STEP_WAIT;
`endif
      end
      STEP_WAIT: begin
        if (uart_byte_valid)           nxt = LOADING;
        else if (cpu_halt)             nxt = HALTED;
        else if (!start_s)             nxt = READY;
        else if (run_ok)               nxt = RUN;
        else if (btn_pulse[B_NEXT])    nxt = STEP_EXEC;
      end
      STEP_EXEC: begin
        if (uart_byte_valid)  nxt = LOADING;
        else if (cpu_halt)    nxt = HALTED;
        else if (!start_s)    nxt = READY;
        else if (instr_done)  nxt = step_s ? STEP_WAIT : RUN;
      end
      HALTED:    if (uart_byte_valid) nxt = LOADING;
      default:   nxt = IDLE;
    endcase
  end

  // state register; outputs decoded from next state so they land with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cpu_en    <= 1'b0;
      cpu_rst   <= 1'b1;
      led_ready <= 1'b0;
      led_halt  <= 1'b0;
      led_run   <= 1'b0;
    end else begin
      state     <= nxt;
      cpu_en    <= (nxt == RUN) || (nxt == STEP_EXEC);
      cpu_rst   <= (nxt == IDLE) || (nxt == LOADING);
      led_ready <= (nxt == READY);
      led_halt  <= (nxt == HALTED);
      led_run   <= (nxt == RUN) || (nxt == STEP_WAIT) || (nxt == STEP_EXEC);
    end
  end

  // display source select; result beats instr beats flags on simultaneous presses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_sel <= 2'd0;
    end else if (btn_pulse[B_RESULT]) begin
      disp_sel <= 2'd0;
    end else if (btn_pulse[B_INSTR]) begin
      disp_sel <= 2'd1;
    end else if (btn_pulse[B_FLAGS]) begin
      disp_sel <= 2'd2;
    end
  end
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: scoreboard bench. A behavioural model pushes expected
// outputs each clock; a monitor pops and compares on the falling edge.
module tb_exec_controller;
  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_byte_valid, uart_load_done, start_cpu, step_mode;
  logic [3:0] btns;   // 0 next, 1 result, 2 instr, 3 flags
  logic       instr_done, cpu_halt;
  logic [7:0] pc, bp_addr;
  logic       cpu_en, cpu_rst, led_ready, led_halt, led_run;
  logic [1:0] disp_sel;

  exec_controller #(.DEBOUNCE_CYCLES(20'd4)) dut (
    .clk            (clk),
    .rst            (rst),
    .uart_byte_valid(uart_byte_valid),
    .uart_load_done (uart_load_done),
    .start_cpu      (start_cpu),
    .step_mode      (step_mode),
    .btn_next       (btns[0]),
    .btn_result     (btns[1]),
    .btn_instr      (btns[2]),
    .btn_flags      (btns[3]),
    .instr_done     (instr_done),
    .cpu_halt       (cpu_halt),
    .pc             (pc),
    .bp_addr        (bp_addr),
    .cpu_en         (cpu_en),
    .cpu_rst        (cpu_rst),
    .disp_sel       (disp_sel),
    .led_ready      (led_ready),
    .led_halt       (led_halt),
    .led_run        (led_run)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       en;
    logic       crst;
    logic [1:0] disp;
    logic       rdy;
    logic       hlt;
    logic       run;
  } obs_t;

  typedef enum int {M_IDLE, M_LOAD, M_READY, M_RUN, M_SWAIT, M_SEXEC, M_HALT} mstate_t;

  obs_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // ---------------- reference model ----------------
  mstate_t    ms;
  logic [5:0] raw_q[$];          // {step, start, btns} as sampled at recent edges
  int         run_len[4];
  bit         run_val[4], acc[4], pul[4];
  logic [1:0] m_disp;
  bit         hold, prev_step;

  always @(posedge clk) begin
    obs_t e;
    if (rst) begin
      ms = M_IDLE; m_disp = 2'd0; hold = 0; prev_step = 0;
      raw_q = '{6'd0, 6'd0};
      for (int b = 0; b < 4; b++) begin
        run_len[b] = 0; run_val[b] = 0; acc[b] = 0; pul[b] = 0;
      end
      e = '{en:1'b0, crst:1'b1, disp:2'd0, rdy:1'b0, hlt:1'b0, run:1'b0};
    end else begin
      logic [5:0] seen;
      mstate_t    nx;
      bit         active, bp_hit, smp, np;
      seen = raw_q.pop_front();    // a switch or button value is seen two edges after it was sampled
      raw_q.push_back({step_mode, start_cpu, btns});
      nx = ms; bp_hit = 0;
      active = (ms == M_RUN) || (ms == M_SWAIT) || (ms == M_SEXEC);
      if (ms == M_LOAD) begin
        if (uart_load_done) nx = M_READY;
      end else if (uart_byte_valid)      nx = M_LOAD;
      else if (active && cpu_halt)       nx = M_HALT;
      else if (active && !seen[4])       nx = M_READY;
      else if (ms == M_READY) begin
        if (seen[4]) nx = seen[5] ? M_SWAIT : M_RUN;
      end else if (ms == M_RUN) begin
        if (seen[5]) nx = M_SWAIT;
`ifdef EXEC_BREAKPOINT_EN
        else if (instr_done && pc == bp_addr) begin nx = M_SWAIT; bp_hit = 1; end
`endif
      end else if (ms == M_SWAIT) begin
        if (!seen[5] && !hold) nx = M_RUN;
        else if (pul[0])       nx = M_SEXEC;
      end else if (ms == M_SEXEC) begin
        if (instr_done) nx = seen[5] ? M_SWAIT : M_RUN;
      end
`ifdef EXEC_BREAKPOINT_EN
      if (bp_hit) hold = 1;
      else if (nx != M_SWAIT || seen[5] != prev_step) hold = 0;
      prev_step = seen[5];
`endif
      if (pul[1])      m_disp = 2'd0;
      else if (pul[2]) m_disp = 2'd1;
      else if (pul[3]) m_disp = 2'd2;
      // a button level is accepted once DB consecutive samples hold the new value
      for (int b = 0; b < 4; b++) begin
        smp = seen[b];
        np  = 0;
        if (smp == run_val[b]) run_len[b]++;
        else begin run_val[b] = smp; run_len[b] = 1; end
        if (smp != acc[b] && run_len[b] >= DB) begin acc[b] = smp; np = smp; end
        pul[b] = np;
      end
      ms = nx;
      e.en   = (ms == M_RUN) || (ms == M_SEXEC);
      e.crst = (ms == M_IDLE) || (ms == M_LOAD);
      e.disp = m_disp;
      e.rdy  = (ms == M_READY);
      e.hlt  = (ms == M_HALT);
      e.run  = (ms == M_RUN) || (ms == M_SWAIT) || (ms == M_SEXEC);
    end
    exp_q.push_back(e);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    obs_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{en:cpu_en, crst:cpu_rst, disp:disp_sel, rdy:led_ready, hlt:led_halt, run:led_run};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got en=%b rst=%b disp=%0d rdy=%b halt=%b run=%b want en=%b rst=%b disp=%0d rdy=%b halt=%b run=%b",
                 $time, a.en, a.crst, a.disp, a.rdy, a.hlt, a.run,
                 e.en, e.crst, e.disp, e.rdy, e.hlt, e.run);
      end
    end
  end

  // count cpu_en windows independently of the model
  int en_rises = 0;
  bit en_prev  = 0;
  always @(negedge clk) begin
    if (cpu_en && !en_prev) en_rises++;
    en_prev = cpu_en;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask

  task automatic press(input int b, input int len);
    btns[b] = 1'b1; cyc(len);
    btns[b] = 1'b0; cyc(len);
  endtask

  task automatic wait_en(input string nm, input int max);
    int n = 0;
    while (!cpu_en && n < max) begin @(negedge clk); n++; end
    chk(nm, int'(cpu_en), 1);
  endtask

  task automatic load_image(input int bytes);
    repeat (bytes) begin uart_byte_valid = 1; cyc(1); uart_byte_valid = 0; cyc(2); end
    chk("loading cpu_rst", int'(cpu_rst), 1);
    uart_load_done = 1; cyc(1); uart_load_done = 0; cyc(1);
  endtask

  initial begin
    int r0;
    rst = 1; uart_byte_valid = 0; uart_load_done = 0; start_cpu = 0; step_mode = 0;
    btns = '0; instr_done = 0; cpu_halt = 0; pc = '0; bp_addr = 8'h05;
    cyc(3);
    chk("reset cpu_en", int'(cpu_en), 0);
    chk("reset cpu_rst", int'(cpu_rst), 1);
    chk("reset disp_sel", int'(disp_sel), 0);
    chk("reset leds", int'({led_ready, led_halt, led_run}), 0);
    rst = 0; cyc(2);

    load_image(3);
    chk("ready led", int'(led_ready), 1);
    chk("ready cpu_rst", int'(cpu_rst), 0);

    // continuous run, instructions retire across the breakpoint address
    step_mode = 0; start_cpu = 1;
    wait_en("run cpu_en", 10);
    chk("run led_run", int'(led_run), 1);
    for (int i = 0; i < 8; i++) begin
      pc = 8'(i); instr_done = 1; cyc(1); instr_done = 0; cyc(1);
    end
`ifdef EXEC_BREAKPOINT_EN
    chk("breakpoint stop", int'(cpu_en), 0);
`else
    chk("no breakpoint", int'(cpu_en), 1);
`endif
    cpu_halt = 1; cyc(1); cpu_halt = 0;
    chk("halt cpu_en", int'(cpu_en), 0);
    chk("halt led_halt", int'(led_halt), 1);
    chk("halt led_run", int'(led_run), 0);

    // new upload leaves HALTED
    start_cpu = 0; cyc(3);
    uart_byte_valid = 1; cyc(1); uart_byte_valid = 0;
    chk("reload cpu_rst", int'(cpu_rst), 1);
    chk("reload led_halt", int'(led_halt), 0);
    cyc(2); uart_load_done = 1; cyc(1); uart_load_done = 0; cyc(1);

    // single step: three presses, three windows
    step_mode = 1; start_cpu = 1; cyc(5);
    chk("step_wait cpu_en", int'(cpu_en), 0);
    chk("step_wait led_run", int'(led_run), 1);
    r0 = en_rises;
    repeat (3) begin
      press(0, 6);
      wait_en("step window", 20);
      instr_done = 1; cyc(1); instr_done = 0; cyc(2);
    end
    chk("step windows", en_rises - r0, 3);
    r0 = en_rises;
    btns[0] = 1; cyc(2); btns[0] = 0; cyc(12);
    chk("glitch no step", en_rises - r0, 0);

    // display select
    press(2, 6); chk("disp instr", int'(disp_sel), 1);
    press(3, 6); chk("disp flags", int'(disp_sel), 2);
    btns[1] = 1; btns[3] = 1; cyc(6); btns = '0; cyc(6);
    chk("disp result wins", int'(disp_sel), 0);

    // asynchronous reset while running
    step_mode = 0;
    wait_en("resume run", 10);
    @(negedge clk); #2; rst = 1; #1;
    chk("async rst cpu_en", int'(cpu_en), 0);
    chk("async rst cpu_rst", int'(cpu_rst), 1);
    chk("async rst led_run", int'(led_run), 0);
    cyc(2); rst = 0; cyc(2);

    // randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      uart_byte_valid = ($urandom_range(0, 59) == 0);
      uart_load_done  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 29) == 0) start_cpu = ~start_cpu;
      if ($urandom_range(0, 29) == 0) step_mode = ~step_mode;
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) btns[b] = ~btns[b];
      instr_done = ($urandom_range(0, 2) == 0);
      cpu_halt   = ($urandom_range(0, 39) == 0);
      pc         = 8'($urandom_range(0, 7));
      cyc(1);
    end
    uart_byte_valid = 0; uart_load_done = 0; instr_done = 0; cpu_halt = 0; btns = '0;
    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
